spi_host: RTL

SPI mode-0 host (initiator) that drives the same four-wire link Xosera's SPI target listens on: SCK, COPI and active-low select as outputs, CIPO as input. Bytes arrive on a valid/ready stream, shift out MSB-first, and each byte received in the same exchange comes back as a one-cycle pulse. Used in on-FPGA loopback/self-test builds and by any host-side design that talks to xosera_main.

---
 rtl/spi_host_pkg.sv | 21 ++
 rtl/spi_host_tick.sv | 31 +++
 rtl/spi_host.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/spi_host_pkg.sv
// Shared definitions for the SPI mode-0 host.
// Holds the state encoding, the SPI mode constants the host and the
// xosera target agree on (CPOL=0, CPHA=0, MSB first) and the counter widths.
package spi_host_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HP_W   = 4;                 // 16 half-periods per byte
    localparam logic [HP_W-1:0] HP_LAST = HP_W'(15);

    // SCK idle level; data is launched while SCK is at this level
    localparam logic CPOL = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_WAIT,
        ST_HOLD,
        ST_GAP
    } state_e;

endpackage

// File: rtl/spi_host_tick.sv
// Half-period timer for spi_host.
// Ports: clk, reset (sync, active-high), restart (realign phase so the next
// tick lands CLK_DIV cycles later), tick (registered one-cycle pulse every
// CLK_DIV clocks, marking the last clk of a half-period).
module spi_host_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(CLK_DIV - 2);

    logic [CNT_W-1:0] cnt;

    // Free-running phase counter; tick is registered so it coincides with cnt==CNT_MAX
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
            tick <= (cnt == CNT_PRE);
        end
    end

endmodule

// File: rtl/spi_host.sv
// SPI mode-0 host: byte stream in (valid/ready), MSB-first shift on
// SCK/COPI with active-low select, received byte out as a one-cycle pulse.
// Ports: clk, reset (sync, active-high); tx_byte_i/tx_last_i/tx_valid_i/
// tx_ready_o byte input stream; rx_byte_o/rx_valid_o received byte;
// busy_o link activity; spi_sck_o/spi_copi_o/spi_cs_o/spi_cipo_i SPI pins.
module spi_host #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned DESEL_HP = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_byte_i,
    input  logic       tx_last_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_byte_o,
    output logic       rx_valid_o,
    output logic       busy_o,
    output logic       spi_sck_o,
    output logic       spi_copi_o,
    input  logic       spi_cipo_i,
    output logic       spi_cs_o
);

    import spi_host_pkg::*;

    localparam logic [HP_W-1:0] GAP_LAST = HP_W'(DESEL_HP - 1);

    state_e            state, state_d;
    logic [BYTE_W-1:0] tx_sr, tx_sr_d, rx_sr, rx_sr_d, rx_byte_d;
    logic [HP_W-1:0]   hp, hp_d;
    logic              last, last_d;
    logic              sck_d, copi_d, cs_d, rx_valid_d, tx_ready_d, busy_d;
    logic              restart, tick, accept_c;
    logic              cipo_meta, cipo_sync;

    assign accept_c = tx_valid_i & tx_ready_o;

    spi_host_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    // CIPO is asynchronous to clk
    always_ff @(posedge clk) begin
        if (reset) begin
            cipo_meta <= 1'b0;
            cipo_sync <= 1'b0;
        end else begin
            cipo_meta <= spi_cipo_i;
            cipo_sync <= cipo_meta;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state;
        tx_sr_d    = tx_sr;
        rx_sr_d    = rx_sr;
        rx_byte_d  = rx_byte_o;
        hp_d       = hp;
        last_d     = last;
        sck_d      = spi_sck_o;
        copi_d     = spi_copi_o;
        cs_d       = spi_cs_o;
        rx_valid_d = 1'b0;
        restart    = 1'b0;

        unique case (state)
            ST_IDLE, ST_WAIT: begin
                if (accept_c) begin
                    state_d = ST_SHIFT;
                    tx_sr_d = tx_byte_i;
                    last_d  = tx_last_i;
                    copi_d  = tx_byte_i[7];
                    cs_d    = 1'b0;
                    sck_d   = CPOL;
                    hp_d    = '0;
                    // A byte chained in the rx_valid cycle continues the running
                    // half-period so SCK phase stays continuous across bytes
                    restart = ~rx_valid_o;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    hp_d = hp + 1'b1;
                    if (hp[0]) begin
                        // end of a high half-period: sample, then SCK falls
                        rx_sr_d = {rx_sr[6:0], cipo_sync};
                        sck_d   = CPOL;
                        if (hp == HP_LAST) begin
                            rx_byte_d  = {rx_sr[6:0], cipo_sync};
                            rx_valid_d = 1'b1;
                            state_d    = last ? ST_HOLD : ST_WAIT;
                        end else begin
                            tx_sr_d = {tx_sr[6:0], 1'b0};
                            copi_d  = tx_sr[6];
                        end
                    end else begin
                        sck_d = ~CPOL;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_d = ST_GAP;
                    cs_d    = 1'b1;
                    hp_d    = '0;
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (hp == GAP_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        hp_d = hp + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cs_d    = 1'b1;
                sck_d   = CPOL;
            end
        endcase

        tx_ready_d = (state_d == ST_IDLE) || (state_d == ST_WAIT);
        busy_d     = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            tx_sr      <= '0;
            rx_sr      <= '0;
            hp         <= '0;
            last       <= 1'b0;
            rx_byte_o  <= '0;
            rx_valid_o <= 1'b0;
            tx_ready_o <= 1'b0;
            busy_o     <= 1'b0;
            spi_sck_o  <= CPOL;
            spi_copi_o <= 1'b0;
            spi_cs_o   <= 1'b1;
        end else begin
            state      <= state_d;
            tx_sr      <= tx_sr_d;
            rx_sr      <= rx_sr_d;
            hp         <= hp_d;
            last       <= last_d;
            rx_byte_o  <= rx_byte_d;
            rx_valid_o <= rx_valid_d;
            tx_ready_o <= tx_ready_d;
            busy_o     <= busy_d;
            spi_sck_o  <= sck_d;
            spi_copi_o <= copi_d;
            spi_cs_o   <= cs_d;
        end
    end

endmodule
